// File: rtl/branch_redirect_unit.sv
// Decode-stage branch/jump resolution: combinational redirect into fetch plus the ID/EX
// stage register, with delay-slot / squash tracking and a sticky delay-slot-transfer error.
module branch_redirect_unit #(
  parameter logic [31:0] TEXT_BASE  = 32'h00400000,
  parameter int unsigned DELAY_SLOT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic [31:0] pc_plus_4,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [31:0] branch_pc,
  output logic        pc_src,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        link_we,
  output logic [4:0]  link_addr,
  output logic [31:0] link_data,
  output logic        slot_err
);

  typedef enum logic [1:0] {StNormal, StSlot, StSquash} st_e;

  st_e         st_q, st_d;
  logic        primed_q;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_pc_q;
  logic        link_we_q, link_we_d;
  logic [4:0]  link_addr_q, link_addr_d;
  logic [31:0] link_data_q, link_data_d;
  logic        slot_err_q, slot_err_d;

  logic [5:0]  op, fn;
  logic [31:0] iaddr, seq, imm, target;
  logic        is_br, is_j, is_jal, is_jr, is_jalr, is_xfer, taken, cond;

  assign rs_addr = ir[25:21];
  assign rt_addr = ir[20:16];

  always_comb begin
    op      = ir[31:26];
    fn      = ir[5:0];
    iaddr   = pc_plus_4 - 32'd8;
    seq     = pc_plus_4 - 32'd4;
    imm     = {{14{ir[15]}}, ir[15:0], 2'b00};
    is_br   = (op[5:2] == 4'b0001);
    is_jal  = (op == 6'h03);
    is_j    = (op == 6'h02) || is_jal;
    is_jr   = (op == 6'h00) && (fn == 6'h08);
    is_jalr = (op == 6'h00) && (fn == 6'h09);
    is_xfer = is_br || is_j || is_jr || is_jalr;

    cond = 1'b0;
    unique case (op[1:0])
      2'b00: cond = (rs_data == rt_data);
      2'b01: cond = (rs_data != rt_data);
      2'b10: cond = ($signed(rs_data) <= 32'sd0);
      2'b11: cond = ($signed(rs_data) > 32'sd0);
      default: cond = 1'b0;
    endcase
    taken = is_br ? cond : (is_j || is_jr || is_jalr);

    if (is_br) begin
      target = seq + imm;
    end else if (is_j) begin
      target = {seq[31:28], ir[25:0], 2'b00};
    end else if (is_jr || is_jalr) begin
      target = rs_data;
    end else begin
      target = seq;
    end

    branch_pc = target;
    pc_src    = primed_q && (st_q == StNormal) && taken;
  end

  always_comb begin
    st_d = StNormal;
    unique case (st_q)
      StNormal: if (pc_src) st_d = (DELAY_SLOT != 0) ? StSlot : StSquash;
      StSlot:   st_d = StNormal;
      StSquash: st_d = StNormal;
      default:  st_d = StNormal;
    endcase

    slot_err_d  = slot_err_q || ((st_q == StSlot) && is_xfer);
    id_valid_d  = primed_q && (st_q != StSquash);
    link_we_d   = id_valid_d && (is_jal || (is_jalr && (ir[15:11] != 5'd0)));
    link_addr_d = is_jal ? 5'd31 : ir[15:11];
    link_data_d = (DELAY_SLOT != 0) ? pc_plus_4 : seq;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q        <= StNormal;
      primed_q    <= 1'b0;
      id_valid_q  <= 1'b0;
      id_instr_q  <= 32'd0;
      id_pc_q     <= TEXT_BASE;
      link_we_q   <= 1'b0;
      link_addr_q <= 5'd0;
      link_data_q <= 32'd0;
      slot_err_q  <= 1'b0;
    end else begin
      st_q        <= st_d;
      primed_q    <= 1'b1;
      id_valid_q  <= id_valid_d;
      id_instr_q  <= ir;
      id_pc_q     <= iaddr;
      link_we_q   <= link_we_d;
      link_addr_q <= link_addr_d;
      link_data_q <= link_data_d;
      slot_err_q  <= slot_err_d;
    end
  end

  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign link_we   = link_we_q;
  assign link_addr = link_addr_q;
  assign link_data = link_data_q;
  assign slot_err  = slot_err_q;

endmodule
